// File: rtl/aes_op_sequencer.sv
// -----------------------------------------------------------------------------
// aes_op_sequencer
//  Single-requester job controller placed in front of an aes_top cipher /
//  inverse-cipher pair. One encrypt or decrypt job is accepted per
//  valid/ready handshake. The job's mode, key and text are registered and
//  held on the engine interface for the whole job. Decrypts run key
//  expansion (kld/kdone) first unless the last expanded decrypt key matches.
//  The 128-bit result is returned on a valid/ready response port. A stalled
//  engine is abandoned after TIMEOUT_CYC cycles with out_err set.
//
// Ports
//  clk, rst                 clock (rising edge) / asynchronous active-low reset
//  in_valid/in_ready        job request handshake
//  in_mode/in_key/in_text   0=encrypt 1=decrypt, job key, job text
//  key_inv                  pulse that invalidates the decrypt key cache
//  out_valid/out_ready      response handshake
//  out_data/out_err         result text, timeout abort flag (data forced to 0)
//  eng_mode/eng_key/eng_text_in   registered job fields driven to aes_top
//  eng_ld/eng_kld           one-cycle start pulses to aes_top
//  eng_done/eng_kdone/eng_text_out  completion strobes and result from aes_top
//  op_cnt                   count of jobs completed without error (wraps)
// -----------------------------------------------------------------------------
module aes_op_sequencer #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [127:0]     in_key,
   input  logic [127:0]     in_text,
   input  logic             key_inv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             out_err,
   output logic             eng_mode,
   output logic             eng_ld,
   output logic             eng_kld,
   output logic [127:0]     eng_key,
   output logic [127:0]     eng_text_in,
   input  logic             eng_done,
   input  logic             eng_kdone,
   input  logic [127:0]     eng_text_out,
   output logic [CNT_W-1:0] op_cnt
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

   typedef enum logic [2:0] {
      IDLE,
      KEXP,
      KWAIT,
      LOAD,
      RUN,
      RESP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [TMR_W-1:0] timer;
   logic             cache_valid;
   logic [127:0]     cache_key;
   logic             accept;
   logic             cache_hit;
   logic             timer_exp;
   logic             timeout_evt;
   logic             run_done;
   logic             kexp_done;

   // A key_inv arriving with the accept must force key expansion, so the
   // cache only counts as a hit when no invalidation is pending this cycle.
   assign accept      = in_valid && (state == IDLE);
   assign cache_hit   = cache_valid && !key_inv && (in_key == cache_key);
   assign timer_exp   = (timer == TMR_W'(TIMEOUT_CYC - 1));
   assign run_done    = (state == RUN) && eng_done;
   assign kexp_done   = (state == KWAIT) && eng_kdone;
   assign timeout_evt = timer_exp &&
                        (((state == KWAIT) && !eng_kdone) ||
                         ((state == RUN)   && !eng_done));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake/strobe decode; strobes are pure state decodes
   // so each lasts exactly the one cycle spent in KEXP or LOAD.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      eng_ld    = 1'b0;
      eng_kld   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = (in_mode && !cache_hit) ? KEXP : LOAD;
            end
         end
         KEXP: begin
            eng_kld   = 1'b1;
            state_nxt = KWAIT;
         end
         KWAIT: begin
            if (eng_kdone) begin
               state_nxt = LOAD;
            end else if (timer_exp) begin
               state_nxt = RESP;
            end
         end
         LOAD: begin
            eng_ld    = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            if (eng_done || timer_exp) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Job registers, wait timer, result capture and completed-job counter.
   // The timer only runs while waiting on the engine and sits at zero
   // elsewhere, so every entry into KWAIT or RUN starts a fresh count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         eng_mode    <= 1'b0;
         eng_key     <= '0;
         eng_text_in <= '0;
         timer       <= '0;
         out_data    <= '0;
         out_err     <= 1'b0;
         op_cnt      <= '0;
      end else begin
         if (accept) begin
            eng_mode    <= in_mode;
            eng_key     <= in_key;
            eng_text_in <= in_text;
         end
         if ((state == KWAIT) || (state == RUN)) begin
            timer <= timer + 1'b1;
         end else begin
            timer <= '0;
         end
         if (run_done) begin
            out_data <= eng_text_out;
            out_err  <= 1'b0;
            op_cnt   <= op_cnt + 1'b1;
         end else if (timeout_evt) begin
            out_data <= '0;
            out_err  <= 1'b1;
         end
      end
   end

   // Decrypt key cache. Invalidation (key_inv or an aborted job) takes
   // priority over a kdone seen in the same cycle, leaving the cache empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cache_valid <= 1'b0;
         cache_key   <= '0;
      end else begin
         if (kexp_done) begin
            cache_key <= eng_key;
         end
         if (key_inv || timeout_evt) begin
            cache_valid <= 1'b0;
         end else if (kexp_done) begin
            cache_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_aes_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_op_sequencer
//  Self-checking bench for aes_op_sequencer. A behavioural engine stands in
//  for aes_top (configurable kdone/done delays, or no answer at all), and a
//  job-level reference model predicts result data, error flag, key-expansion
//  pulses, completion latency and the completed-job count.
// -----------------------------------------------------------------------------
module tb_aes_op_sequencer;

   localparam int TIMEOUT_CYC = 64;
   localparam int CNT_W       = 16;

   localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_C   = 128'h603deb1015ca71be2b73aef0857d7781;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             in_mode;
   logic [127:0]     in_key;
   logic [127:0]     in_text;
   logic             key_inv;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_data;
   logic             out_err;
   logic             eng_mode;
   logic             eng_ld;
   logic             eng_kld;
   logic [127:0]     eng_key;
   logic [127:0]     eng_text_in;
   logic             eng_done;
   logic             eng_kdone;
   logic [127:0]     eng_text_out;
   logic [CNT_W-1:0] op_cnt;

   int checks = 0;
   int errors = 0;

   // Engine model controls, written only by the stimulus process.
   int   eng_kdly  = 0;
   int   eng_ddly  = 0;
   logic hang_k    = 1'b0;
   logic hang_d    = 1'b0;
   int   spur_req  = 0;

   // Engine model private state.
   int           kd_tmr   = -1;
   int           dn_tmr   = -1;
   int           spur_ack = 0;
   logic [127:0] pend_out = '0;

   // Pulse counters from the monitor.
   int kld_cnt = 0;
   int ld_cnt  = 0;

   // Reference model of the decrypt key cache and completed-job count.
   logic             ref_valid = 1'b0;
   logic [127:0]     ref_key   = '0;
   logic [CNT_W-1:0] ref_cnt   = '0;

   logic [127:0] key_pool [3];

   aes_op_sequencer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_mode      (in_mode),
      .in_key       (in_key),
      .in_text      (in_text),
      .key_inv      (key_inv),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_err      (out_err),
      .eng_mode     (eng_mode),
      .eng_ld       (eng_ld),
      .eng_kld      (eng_kld),
      .eng_key      (eng_key),
      .eng_text_in  (eng_text_in),
      .eng_done     (eng_done),
      .eng_kdone    (eng_kdone),
      .eng_text_out (eng_text_out),
      .op_cnt       (op_cnt)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cipher stand-in: the real FIPS-197 vector pair, otherwise a simple
   // key-dependent scramble that differs between encrypt and decrypt.
   function automatic logic [127:0] aesModel(input logic m, input logic [127:0] k,
                                             input logic [127:0] t);
      if (!m && (k == AES_KEY) && (t == AES_PT)) return AES_CT;
      if (m && (k == AES_KEY) && (t == AES_CT)) return AES_PT;
      if (m) return {t[63:0], t[127:64]} ^ k ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
      return t ^ {k[119:0], k[127:120]};
   endfunction

   // Behavioural aes_top: answers kld after eng_kdly cycles and ld after
   // eng_ddly cycles unless told to hang; forgets everything under reset.
   always @(negedge clk) begin
      eng_done  = 1'b0;
      eng_kdone = 1'b0;
      if (!rst) begin
         kd_tmr = -1;
         dn_tmr = -1;
      end else begin
         if (spur_ack != spur_req) begin
            eng_done     = 1'b1;
            eng_kdone    = 1'b1;
            eng_text_out = {4{32'hdeadbeef}};
            spur_ack     = spur_req;
         end
         if (kd_tmr == 0) eng_kdone = 1'b1;
         if (kd_tmr >= 0) kd_tmr--;
         if (dn_tmr == 0) begin
            eng_done     = 1'b1;
            eng_text_out = pend_out;
         end
         if (dn_tmr >= 0) dn_tmr--;
         if (eng_kld && !hang_k) kd_tmr = eng_kdly;
         if (eng_ld && !hang_d) begin
            dn_tmr   = eng_ddly;
            pend_out = aesModel(eng_mode, eng_key, eng_text_in);
         end
      end
   end

   // Pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (eng_kld) kld_cnt++;
      if (eng_ld)  ld_cnt++;
   end

   task automatic checkOutput(input string tag, input logic [127:0] obs,
                              input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one complete job through the handshake and checks it against the
   // reference model. Called on a negedge with the DUT idle.
   task automatic applyStimulus(input logic mode, input logic [127:0] key,
                                input logic [127:0] text, input logic inv,
                                input logic hk, input logic hd,
                                input int kdly, input int ddly, input int hold);
      logic         exp_kld;
      logic         k_abort;
      logic         exp_err;
      logic [127:0] exp_data;
      int           n;
      int           ld_at;

      if (inv) ref_valid = 1'b0;
      exp_kld  = mode && (!ref_valid || (ref_key != key));
      k_abort  = exp_kld && hk;
      exp_err  = k_abort || hd;
      exp_data = exp_err ? 128'h0 : aesModel(mode, key, text);
      if (exp_err) begin
         ref_valid = 1'b0;
      end else begin
         ref_cnt = ref_cnt + 1'b1;
         if (exp_kld) begin
            ref_valid = 1'b1;
            ref_key   = key;
         end
      end

      kld_cnt  = 0;
      ld_cnt   = 0;
      hang_k   = hk;
      hang_d   = hd;
      eng_kdly = kdly;
      eng_ddly = ddly;
      in_valid = 1'b1;
      in_mode  = mode;
      in_key   = key;
      in_text  = text;
      key_inv  = inv;
      checkOutput("in_ready_idle", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      key_inv  = 1'b0;
      in_text  = ~text;
      checkOutput("eng_key_reg", eng_key, key);
      checkOutput("eng_text_reg", eng_text_in, text);
      checkOutput("eng_mode_reg", eng_mode, mode);
      checkOutput("in_ready_busy", in_ready, 1'b0);

      n     = 0;
      ld_at = -1;
      while ((n < 300) && !out_valid) begin
         if (eng_ld) ld_at = n;
         @(negedge clk);
         n++;
      end
      checkOutput("resp_arrived", out_valid, 1'b1);
      checkOutput("out_data", out_data, exp_data);
      checkOutput("out_err", out_err, exp_err);
      checkOutput("kld_pulses", kld_cnt, exp_kld ? 1 : 0);
      checkOutput("ld_pulses", ld_cnt, k_abort ? 0 : 1);
      checkOutput("op_cnt", op_cnt, ref_cnt);
      if (!k_abort) begin
         checkOutput("ld_to_resp_cycles", n - ld_at, hd ? (TIMEOUT_CYC + 1) : (ddly + 2));
      end

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", out_valid, 1'b1);
         checkOutput("hold_data", out_data, exp_data);
         checkOutput("hold_in_ready", in_ready, 1'b0);
         checkOutput("hold_mode", eng_mode, mode);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("resp_released", out_valid, 1'b0);
      checkOutput("back_to_idle", in_ready, 1'b1);
   endtask

   initial begin
      int           n;
      logic         seen;
      logic         m;
      logic [127:0] k;
      logic [127:0] t;

      key_pool[0] = AES_KEY;
      key_pool[1] = KEY_B;
      key_pool[2] = KEY_C;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_key    = '0;
      in_text   = '0;
      key_inv   = 1'b0;
      out_ready = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 1'b1);
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_out_data", out_data, 128'h0);
      checkOutput("rst_op_cnt", op_cnt, 0);
      checkOutput("rst_eng_key", eng_key, 128'h0);
      checkOutput("rst_eng_ld", eng_ld, 1'b0);
      rst = 1'b1;
      @(negedge clk);

      // T1 + T5: encrypt, response held off for five cycles.
      applyStimulus(1'b0, AES_KEY, AES_PT, 1'b0, 1'b0, 1'b0, 0, 3, 5);
      // T2: decrypt miss, then decrypt hit with the same key.
      applyStimulus(1'b1, AES_KEY, AES_CT, 1'b0, 1'b0, 1'b0, 2, 1, 0);
      applyStimulus(1'b1, AES_KEY, AES_CT, 1'b0, 1'b0, 1'b0, 2, 0, 1);
      checkOutput("t2_op_cnt_3", op_cnt, 3);
      checkOutput("t2_plaintext", out_data, AES_PT);
      // T3: invalidation on the accept cycle of a would-be cache hit.
      applyStimulus(1'b1, AES_KEY, AES_CT, 1'b1, 1'b0, 1'b0, 1, 2, 0);

      // Stray strobes while idle must not count or respond.
      spur_req++;
      repeat (3) @(negedge clk);
      checkOutput("spur_no_resp", out_valid, 1'b0);
      checkOutput("spur_op_cnt", op_cnt, ref_cnt);

      // T4: engine never finishes (cache hit), then same key needs kld again.
      applyStimulus(1'b1, AES_KEY, AES_CT, 1'b0, 1'b0, 1'b1, 0, 0, 0);
      applyStimulus(1'b1, AES_KEY, AES_CT, 1'b0, 1'b0, 1'b0, 0, 1, 0);
      // Key expansion never finishes.
      applyStimulus(1'b1, KEY_B, 128'h1234, 1'b0, 1'b1, 1'b0, 0, 0, 0);

      // Randomised jobs over a small key pool to mix hits and misses.
      for (int j = 0; j < 24; j++) begin
         m = 1'(($urandom_range(0, 2) != 0));
         k = key_pool[$urandom_range(0, 2)];
         t = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus(m, k, t, 1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
                       $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
      end

      // T6: asynchronous reset four cycles after eng_ld.
      eng_kdly = 1;
      eng_ddly = 10;
      hang_k   = 1'b0;
      hang_d   = 1'b0;
      in_valid = 1'b1;
      in_mode  = 1'b1;
      in_key   = KEY_C;
      in_text  = 128'hfeed;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!eng_ld && (n < 50)) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t6_ld_seen", eng_ld, 1'b1);
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("t6_in_ready", in_ready, 1'b1);
      checkOutput("t6_out_valid", out_valid, 1'b0);
      checkOutput("t6_out_data", out_data, 128'h0);
      checkOutput("t6_out_err", out_err, 1'b0);
      checkOutput("t6_eng_ld", eng_ld, 1'b0);
      checkOutput("t6_eng_kld", eng_kld, 1'b0);
      checkOutput("t6_eng_mode", eng_mode, 1'b0);
      checkOutput("t6_eng_key", eng_key, 128'h0);
      checkOutput("t6_eng_text", eng_text_in, 128'h0);
      checkOutput("t6_op_cnt", op_cnt, 0);
      repeat (2) @(negedge clk);
      rst       = 1'b1;
      ref_valid = 1'b0;
      ref_cnt   = '0;
      seen      = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checkOutput("t6_no_response", seen, 1'b0);
      applyStimulus(1'b1, KEY_C, 128'hfeed, 1'b0, 1'b0, 1'b0, 0, 2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
